// File: rtl/axil_memtest_pkg.sv
// Shared types and constants for the AXI-lite memory tester.
// Holds the FSM state encoding, LFSR polynomial and AXI response codes.
package axil_memtest_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    FINISH
  } state_t;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  // One right-shift step of the Galois LFSR.
  function automatic logic [31:0] lfsr_advance(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/taxi_axil_if.sv
// AXI-lite interface bundle with separate write and read modports.
interface taxi_axil_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport wr_mst (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  modport rd_mst (
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport wr_slv (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );

  modport rd_slv (
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/memtest_lfsr.sv
// 32-bit Galois LFSR data generator; load has priority over step.
module memtest_lfsr
  import axil_memtest_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= seed;
    end else if (step) begin
      value <= lfsr_advance(value);
    end
  end

endmodule

// File: rtl/axil_memtest.sv
// AXI-lite memory tester: writes an LFSR pattern over a word range, reads it back, counts errors.
// Optional per-handshake watchdog enabled with `define AXIL_MEMTEST_TIMEOUT_EN.
module axil_memtest
  import axil_memtest_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned WORDS       = 1024,
  parameter logic [31:0] SEED        = 32'hACE1_2345,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  taxi_axil_if.wr_mst m_axil_wr,
  taxi_axil_if.rd_mst m_axil_rd,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr
);

  if (WORDS < 1 || WORDS > 65535 || TIMEOUT_CYC < 1 ||
      ADDR_BASE[1:0] != 2'b00 || SEED == 32'h0) begin : g_bad_cfg
    $error("axil_memtest: illegal parameter set");
  end

  state_t      state;
  logic [15:0] idx;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        awvalid;
  logic        wvalid;
  logic        bready;
  logic        arvalid;
  logic        rready;

  logic [31:0] lfsr_value;
  logic        lfsr_load;
  logic        lfsr_step;
  logic        start_ok;
  logic        aw_ok;
  logic        w_ok;
  logic        last;
  logic        rd_bad;
  logic        waiting;
  logic        advance;
  logic        err_hit;
  logic        tmo_hit;

  assign m_axil_wr.awaddr  = addr;
  assign m_axil_wr.awprot  = '0;
  assign m_axil_wr.awvalid = awvalid;
  assign m_axil_wr.wdata   = wdata;
  assign m_axil_wr.wstrb   = '1;
  assign m_axil_wr.wvalid  = wvalid;
  assign m_axil_wr.bready  = bready;
  assign m_axil_rd.araddr  = addr;
  assign m_axil_rd.arprot  = '0;
  assign m_axil_rd.arvalid = arvalid;
  assign m_axil_rd.rready  = rready;

  assign pass = done && (err_count == '0);

  assign start_ok = start && (state == IDLE || state == FINISH);
  assign aw_ok    = !awvalid || m_axil_wr.awready;
  assign w_ok     = !wvalid || m_axil_wr.wready;
  assign last     = (idx == 16'(WORDS - 1));
  // Data miscompare and bad response on the same beat are one error.
  assign rd_bad   = (m_axil_rd.rdata != lfsr_value) || (m_axil_rd.rresp != RESP_OKAY);
  assign waiting  = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_RESP);

  always_comb begin
    advance = 1'b0;
    case (state)
      WR_REQ:  advance = aw_ok && w_ok;
      WR_RESP: advance = m_axil_wr.bvalid;
      RD_REQ:  advance = m_axil_rd.arready;
      RD_RESP: advance = m_axil_rd.rvalid;
      default: advance = 1'b0;
    endcase
  end

`ifdef AXIL_MEMTEST_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  assign tmo_hit = waiting && !advance && (tmo_cnt == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || !waiting || advance) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    err_hit = tmo_hit;
    if (state == WR_RESP && m_axil_wr.bvalid && m_axil_wr.bresp != RESP_OKAY) begin
      err_hit = 1'b1;
    end
    if (state == RD_RESP && m_axil_rd.rvalid && rd_bad) begin
      err_hit = 1'b1;
    end
  end

  // The read pass restarts the sequence from SEED on the final write response.
  always_comb begin
    lfsr_load = start_ok;
    lfsr_step = 1'b0;
    case (state)
      WR_RESP: begin
        if (m_axil_wr.bvalid) begin
          if (last) lfsr_load = 1'b1;
          else      lfsr_step = 1'b1;
        end
      end
      RD_RESP: lfsr_step = m_axil_rd.rvalid;
      default: lfsr_step = 1'b0;
    endcase
  end

  memtest_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .seed  (SEED),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      addr           <= '0;
      wdata          <= '0;
      awvalid        <= 1'b0;
      wvalid         <= 1'b0;
      bready         <= 1'b0;
      arvalid        <= 1'b0;
      rready         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      if (err_hit) begin
        if (err_count != '1) err_count <= err_count + 16'd1;
        if (err_count == '0) first_err_addr <= addr;
      end

      if (tmo_hit) begin
        awvalid <= 1'b0;
        wvalid  <= 1'b0;
        bready  <= 1'b0;
        arvalid <= 1'b0;
        rready  <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b1;
        state   <= FINISH;
      end else begin
        case (state)
          IDLE, FINISH: begin
            if (start) begin
              err_count      <= '0;
              first_err_addr <= '0;
              done           <= 1'b0;
              busy           <= 1'b1;
              idx            <= '0;
              addr           <= ADDR_BASE;
              wdata          <= SEED;
              awvalid        <= 1'b1;
              wvalid         <= 1'b1;
              state          <= WR_REQ;
            end
          end
          WR_REQ: begin
            if (m_axil_wr.awready) awvalid <= 1'b0;
            if (m_axil_wr.wready)  wvalid  <= 1'b0;
            if (aw_ok && w_ok) begin
              bready <= 1'b1;
              state  <= WR_RESP;
            end
          end
          WR_RESP: begin
            if (m_axil_wr.bvalid) begin
              bready <= 1'b0;
              if (last) begin
                idx     <= '0;
                addr    <= ADDR_BASE;
                arvalid <= 1'b1;
                state   <= RD_REQ;
              end else begin
                idx     <= idx + 16'd1;
                addr    <= addr + 32'd4;
                wdata   <= lfsr_advance(lfsr_value);
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                state   <= WR_REQ;
              end
            end
          end
          RD_REQ: begin
            if (m_axil_rd.arready) begin
              arvalid <= 1'b0;
              rready  <= 1'b1;
              state   <= RD_RESP;
            end
          end
          RD_RESP: begin
            if (m_axil_rd.rvalid) begin
              rready <= 1'b0;
              if (last) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FINISH;
              end else begin
                idx     <= idx + 16'd1;
                addr    <= addr + 32'd4;
                arvalid <= 1'b1;
                state   <= RD_REQ;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axil_memtest.sv
// Directed bench for axil_memtest against a configurable AXI-lite memory stub.
// Timeout scenario is exercised only when AXIL_MEMTEST_TIMEOUT_EN is defined.
module tb_axil_memtest;
  import axil_memtest_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned NW   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clr_stats = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;

  int checks = 0;
  int errors = 0;

  taxi_axil_if axil ();

  axil_memtest #(
    .ADDR_BASE   (BASE),
    .WORDS       (NW),
    .SEED        (32'hACE1_2345),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .m_axil_wr      (axil),
    .m_axil_rd      (axil),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;

  // Stub slave knobs, set by the test tasks.
  int unsigned aw_lat = 0, w_lat = 0, ar_lat = 0;
  int corrupt_word = -1, rresp_word = -1, bresp_word = -1;
  bit hang_b = 1'b0;

  logic [31:0] mem [0:NW-1];
  logic        aw_got, w_got, b_pend, r_pend;
  int unsigned aw_wait, w_wait, ar_wait;
  int          aw_idx, ar_idx;
  logic [31:0] wd;
  int          writes, reads, aw_hs, w_hs, viol;

  assign axil.awready = axil.awvalid && !aw_got && (aw_wait >= aw_lat);
  assign axil.wready  = axil.wvalid && !w_got && (w_wait >= w_lat);
  assign axil.arready = axil.arvalid && !r_pend && (ar_wait >= ar_lat);

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      axil.bvalid <= 0; axil.rvalid <= 0; axil.bresp <= 0; axil.rresp <= 0; axil.rdata <= 0;
    end else begin
      if (axil.awvalid && axil.awready) begin
        aw_got <= 1; aw_idx <= int'((axil.awaddr - BASE) >> 2); aw_hs <= aw_hs + 1; aw_wait <= 0;
      end else if (axil.awvalid && aw_got) viol <= viol + 1;
      else if (axil.awvalid) aw_wait <= aw_wait + 1;

      if (axil.wvalid && axil.wready) begin
        w_got <= 1; wd <= axil.wdata; w_hs <= w_hs + 1; w_wait <= 0;
        if (axil.wstrb !== 4'hF) viol <= viol + 1;
      end else if (axil.wvalid && w_got) viol <= viol + 1;
      else if (axil.wvalid) w_wait <= w_wait + 1;

      if (axil.arvalid && (aw_got || w_got || b_pend || axil.awvalid || axil.wvalid)) viol <= viol + 1;
      if ((axil.awvalid || axil.wvalid) && r_pend) viol <= viol + 1;

      if (aw_got && w_got && !b_pend) begin
        mem[aw_idx] <= wd;
        b_pend <= 1;
        axil.bvalid <= !hang_b;
        axil.bresp <= (aw_idx == bresp_word) ? 2'b10 : 2'b00;
      end
      if (axil.bvalid && axil.bready) begin
        axil.bvalid <= 0; b_pend <= 0; aw_got <= 0; w_got <= 0; writes <= writes + 1;
      end

      if (axil.arvalid && axil.arready) begin
        r_pend <= 1; ar_idx <= int'((axil.araddr - BASE) >> 2); ar_wait <= 0;
      end else if (axil.arvalid && !r_pend) ar_wait <= ar_wait + 1;
      if (r_pend && !axil.rvalid) begin
        axil.rvalid <= 1;
        axil.rdata <= mem[ar_idx] ^ ((ar_idx == corrupt_word) ? 32'h1 : 32'h0);
        axil.rresp <= (ar_idx == rresp_word) ? 2'b10 : 2'b00;
      end
      if (axil.rvalid && axil.rready) begin
        axil.rvalid <= 0; r_pend <= 0; reads <= reads + 1;
      end
    end
    if (clr_stats) begin
      writes <= 0; reads <= 0; aw_hs <= 0; w_hs <= 0; viol <= 0;
    end
  end

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_wait done=%b required 1", tag, done);
    end
  endtask

  task automatic run_once(input string tag);
    @(negedge clk); start = 1; clr_stats = 1;
    @(negedge clk); start = 0; clr_stats = 0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_after_start busy=%b done=%b required busy=1 done=0", tag, busy, done);
    end
    wait_done(tag);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, pass, axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 00000000",
               {busy, done, pass, axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready});
    end
    checks++;
    if (err_count !== 16'h0 || first_err_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_err got %h/%h required 0000/00000000", err_count, first_err_addr);
    end
    checks++;
    if (axil.awaddr !== 32'h0 || axil.wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr_data got %h/%h required 0/0", axil.awaddr, axil.wdata);
    end
    rst = 0;
  endtask

  task automatic check_stats(input string tag);
    checks++;
    if (writes !== NW || reads !== NW || aw_hs !== NW || w_hs !== NW) begin
      errors++;
      $display("FAIL %s_counts wr=%0d rd=%0d aw=%0d w=%0d required %0d each", tag, writes, reads, aw_hs, w_hs, NW);
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL %s_protocol violations=%0d required 0", tag, viol);
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 16'h0 || first_err_addr !== 32'h0) begin
      errors++;
      $display("FAIL %s_result pass=%b err=%0d first=%h required 1/0/0", tag, pass, err_count, first_err_addr);
    end
  endtask

  task automatic test_basic();
    run_once("basic");
    check_stats("basic");
    checks++;
    if (mem[0] !== 32'hACE1_2345 || mem[1] !== 32'hD650_91A1 || mem[2] !== 32'hEB08_48D3) begin
      errors++;
      $display("FAIL basic_pattern got %h %h %h required ace12345 d65091a1 eb0848d3", mem[0], mem[1], mem[2]);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_finish got %b required 0", busy);
    end
  endtask

  task automatic test_wr_skew();
    aw_lat = 0; w_lat = 3;
    run_once("skew_aw_first");
    check_stats("skew_aw_first");
    aw_lat = 1; w_lat = 1; ar_lat = 2;
    run_once("skew_same_cycle");
    check_stats("skew_same_cycle");
    aw_lat = 0; w_lat = 0; ar_lat = 0;
  endtask

  task automatic test_start_ignored();
    @(negedge clk); start = 1; clr_stats = 1;
    @(negedge clk); start = 0; clr_stats = 0;
    repeat (6) @(negedge clk);
    start = 1;
    @(negedge clk); start = 0;
    wait_done("start_ignored");
    check_stats("start_ignored");
  endtask

  task automatic test_errors();
    int cw [5] = '{5, -1, 3, -1, 2};
    int rw [5] = '{-1, 0, 3, -1, 6};
    int bw [5] = '{-1, -1, -1, 7, -1};
    logic [15:0] exp_err [5] = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd2};
    logic [31:0] exp_first [5] = '{BASE + 32'd20, BASE, BASE + 32'd12, BASE + 32'd28, BASE + 32'd8};
    for (int i = 0; i < 5; i++) begin
      corrupt_word = cw[i]; rresp_word = rw[i]; bresp_word = bw[i];
      run_once($sformatf("err%0d", i));
      checks++;
      if (err_count !== exp_err[i] || first_err_addr !== exp_first[i] || pass !== 1'b0) begin
        errors++;
        $display("FAIL err%0d_result err=%0d first=%h pass=%b required %0d/%h/0",
                 i, err_count, first_err_addr, pass, exp_err[i], exp_first[i]);
      end
    end
    corrupt_word = -1; rresp_word = -1; bresp_word = -1;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    corrupt_word = 0;
    @(negedge clk); start = 1; clr_stats = 1;
    @(negedge clk); start = 0; clr_stats = 0;
    while (!(axil.rready === 1'b1 && axil.araddr === BASE + 32'd8) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (axil.rready !== 1'b1 || err_count !== 16'd1) begin
      errors++;
      $display("FAIL midrst_reach rready=%b err=%0d required 1/1", axil.rready, err_count);
    end
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL midrst_state got %0d required %0d", dut.state, IDLE);
    end
    checks++;
    if ({busy, done, pass, axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready} !== 8'h00 ||
        err_count !== 16'h0 || first_err_addr !== 32'h0) begin
      errors++;
      $display("FAIL midrst_outputs ctrl=%b err=%0d first=%h required all 0",
               {busy, done, pass, axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready},
               err_count, first_err_addr);
    end
    corrupt_word = -1;
    @(negedge clk); rst = 0;
    run_once("after_midrst");
    check_stats("after_midrst");
  endtask

`ifdef AXIL_MEMTEST_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    int bcyc = 0;
    hang_b = 1;
    @(negedge clk); start = 1; clr_stats = 1;
    @(negedge clk); start = 0; clr_stats = 0;
    while (done !== 1'b1 && n < 200) begin
      if (axil.bready === 1'b1) bcyc++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bcyc !== 8) begin
      errors++;
      $display("FAIL timeout_finish done=%b busy=%b bready_cycles=%0d required 1/0/8", done, busy, bcyc);
    end
    checks++;
    if (err_count !== 16'd1 || first_err_addr !== BASE) begin
      errors++;
      $display("FAIL timeout_err err=%0d first=%h required 1/%h", err_count, first_err_addr, BASE);
    end
    hang_b = 0;
    rst = 1;
    @(negedge clk); rst = 0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wr_skew();
    test_start_ignored();
    test_errors();
    test_reset_mid();
`ifdef AXIL_MEMTEST_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
